// File: rtl/nonce_search.sv
// nonce_search: latches a block header and a nonce range, then hashes each
// nonce in ascending order with a byte-serial 24-bit toy hash. Reports the
// first nonce whose H0 is below the target (valid) or that the range ran out
// (exhausted).
// Optional feature macro: NONCE_SEARCH_CONT_EN -- when defined, a hit does not
// end the search; every hitting nonce in the range is reported.

module nonce_search #(
  parameter int          HDR_BYTES = 12,
  parameter logic [23:0] INIT_H    = 24'h0189FE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*HDR_BYTES-1:0] header,
  input  logic [7:0]             target,
  input  logic [31:0]            nonce_start,
  input  logic [31:0]            nonce_end,
  output logic                   busy,
  output logic                   valid,
  output logic [31:0]            nonce,
  output logic                   exhausted,
  output logic [23:0]            hash_out
);

  localparam int HDR_W     = 8 * HDR_BYTES;
  localparam int MSG_BYTES = HDR_BYTES + 4;
  localparam int MSG_W     = 8 * MSG_BYTES;
  localparam int CNT_W     = $clog2(MSG_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MSG_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    CHECK,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [HDR_W-1:0] header_q, header_d;
  logic [7:0]       target_q, target_d;
  logic [31:0]      cur_q, cur_d;
  logic [31:0]      end_q, end_d;
  logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
  logic [7:0]       h0_q, h0_d;
  logic [7:0]       h1_q, h1_d;
  logic [7:0]       h2_q, h2_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [31:0]      nonce_q, nonce_d;
  logic             exhausted_q, exhausted_d;
  logic [23:0]      hashOut_q, hashOut_d;

  logic [MSG_W-1:0] msgShift;
  logic [7:0]       curByte;
  logic [7:0]       mixT;
  logic             hit;
  logic             atEnd;
  logic             stopSearch;

  // Pick the message byte for this round, mix it into the hash state and
  // decide whether the current nonce ends the search.
  always_comb begin
    msgShift = {header_q, cur_q} << (8 * byteCnt_q);
    curByte  = msgShift[MSG_W-1 -: 8];
    mixT     = h2_q + curByte;
    hit      = (h0_q < target_q);
    atEnd    = (cur_q == end_q);
`ifdef NONCE_SEARCH_CONT_EN
    stopSearch = atEnd;
`else
    stopSearch = hit || atEnd;
`endif
  end

  // Next-state and output logic; pulses default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    target_d    = target_q;
    cur_d       = cur_q;
    end_d       = end_q;
    byteCnt_d   = byteCnt_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    nonce_d     = nonce_q;
    exhausted_d = 1'b0;
    hashOut_d   = hashOut_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          header_d           = header;
          target_d           = target;
          cur_d              = nonce_start;
          end_d              = nonce_end;
          byteCnt_d          = '0;
          {h0_d, h1_d, h2_d} = INIT_H;
          busy_d             = 1'b1;
          state_d            = (nonce_end < nonce_start) ? DONE : HASH;
        end
      end

      HASH: begin
        h2_d = h1_q ^ mixT;
        h1_d = h0_q + mixT;
        h0_d = {mixT[4:0], mixT[7:5]} ^ h2_q;
        if (byteCnt_q == LAST_BYTE) begin
          byteCnt_d = '0;
          state_d   = CHECK;
        end else begin
          byteCnt_d = byteCnt_q + 1'b1;
        end
      end

      CHECK: begin
        hashOut_d = {h0_q, h1_q, h2_q};
        if (hit) begin
          valid_d = 1'b1;
          nonce_d = cur_q;
        end
        if (stopSearch) begin
          busy_d      = 1'b0;
          exhausted_d = !hit;
          state_d     = DONE;
        end else begin
          cur_d              = cur_q + 32'd1;
          byteCnt_d          = '0;
          {h0_d, h1_d, h2_d} = INIT_H;
          state_d            = HASH;
        end
      end

      DONE: begin
        // busy is still high only when an empty range skipped hashing.
        exhausted_d = busy_q;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any search in flight and clears the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      header_q    <= '0;
      target_q    <= '0;
      cur_q       <= '0;
      end_q       <= '0;
      byteCnt_q   <= '0;
      h0_q        <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      nonce_q     <= '0;
      exhausted_q <= 1'b0;
      hashOut_q   <= '0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      target_q    <= target_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      byteCnt_q   <= byteCnt_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      nonce_q     <= nonce_d;
      exhausted_q <= exhausted_d;
      hashOut_q   <= hashOut_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign nonce     = nonce_q;
  assign exhausted = exhausted_q;
  assign hash_out  = hashOut_q;

endmodule

// File: tb/tb_nonce_search.sv
// tb_nonce_search: table of search requests with expectations computed by a
// plain-arithmetic hash/search model, plus hand-written reset and start-hold
// sequences.

module tb_nonce_search;

  logic        clk;
  logic        reset;
  logic        start;
  logic [95:0] header;
  logic [7:0]  target;
  logic [31:0] nonce_start;
  logic [31:0] nonce_end;
  logic        busy;
  logic        valid;
  logic [31:0] nonce;
  logic        exhausted;
  logic [23:0] hash_out;

  int total = 0;
  int bad   = 0;
  int edgeCnt = 0;
  int startEdge = 0;
  logic [31:0] expNonceReg = '0;
  logic [23:0] expHashReg  = '0;

  typedef struct {
    logic [95:0] hdr;
    logic [7:0]  tgt;
    logic [31:0] ns;
    logic [31:0] ne;
    bit          isEmpty;
    bit          expHit;
    logic [31:0] expNonce;
    logic [23:0] expHash;
    int          expEdge;
    int          span;
    int          hitCount;
    logic [31:0] lastHitNonce;
    bit          finalMiss;
  } vec_t;

  vec_t vecs[12];

  nonce_search dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .header      (header),
    .target      (target),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .busy        (busy),
    .valid       (valid),
    .nonce       (nonce),
    .exhausted   (exhausted),
    .hash_out    (hash_out)
  );

  // Free-running clock and an edge counter used to time results.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Toy hash of header||nonce, byte by byte, using integer arithmetic.
  function automatic logic [23:0] refHash(input logic [95:0] hdr, input logic [31:0] n);
    logic [127:0] msg;
    int h0, h1, h2, b, t, n0, n1, n2;
    msg = {hdr, n};
    h0 = 'h01; h1 = 'h89; h2 = 'hFE;
    for (int i = 0; i < 16; i++) begin
      b  = int'(msg[127 - 8*i -: 8]);
      t  = (h2 + b) % 256;
      n2 = h1 ^ t;
      n1 = (h0 + t) % 256;
      n0 = (((t * 8) % 256) + (t / 32)) ^ h2;
      h0 = n0; h1 = n1; h2 = n2;
    end
    return {h0[7:0], h1[7:0], h2[7:0]};
  endfunction

  // Walk the whole range and record first hit, hit count and final outcome.
  function automatic vec_t makeVec(input logic [95:0] hdr, input logic [7:0] tgt,
                                   input logic [31:0] ns, input logic [31:0] ne);
    vec_t v;
    longint lo, hi;
    logic [23:0] h;
    v.hdr = hdr; v.tgt = tgt; v.ns = ns; v.ne = ne;
    v.expHit = 0; v.expNonce = '0; v.expHash = '0; v.hitCount = 0;
    v.lastHitNonce = '0; v.finalMiss = 1;
    lo = ns; hi = ne;
    v.isEmpty = (hi < lo);
    if (v.isEmpty) begin
      v.expEdge = 1;
      v.span    = 1;
      return v;
    end
    v.span    = 17 * int'(hi - lo + 1);
    v.expEdge = v.span;
    v.expHash = refHash(hdr, ne);
    for (longint k = lo; k <= hi; k++) begin
      h = refHash(hdr, 32'(k));
      if (h[23:16] < tgt) begin
        if (!v.expHit) begin
          v.expHit   = 1;
          v.expNonce = 32'(k);
          v.expHash  = h;
          v.expEdge  = 17 * int'(k - lo + 1);
        end
        v.hitCount++;
        v.lastHitNonce = 32'(k);
      end
      if (k == hi) v.finalMiss = !(h[23:16] < tgt);
    end
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive a request; optionally keep start high with junk inputs afterwards.
  task automatic applyStimulus(input vec_t v, input int hold);
    @(negedge clk);
    header = v.hdr; target = v.tgt; nonce_start = v.ns; nonce_end = v.ne;
    start = 1'b1;
    @(posedge clk); #1;
    startEdge = edgeCnt;
    checkValue("busy after start", 64'(busy), 64'(1));
    for (int i = 0; i < hold; i++) begin
      header      = {$urandom, $urandom, $urandom};
      target      = 8'($urandom);
      nonce_start = $urandom;
      nonce_end   = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Wait for the result pulse and compare against the model.
  task automatic checkOutput(input vec_t v);
    bit got;
    int evEdge;
    bit expBusy;
    got = 0;
    for (int i = 0; i < v.expEdge + 20 && !got; i++) begin
      @(posedge clk); #1;
      if (valid || exhausted) got = 1;
    end
    checkValue("result seen", 64'(got), 64'(1));
    if (!got) return;
    evEdge = edgeCnt - startEdge;
    checkValue("result edge", 64'(evEdge), 64'(v.expEdge));
    checkValue("valid", 64'(valid), 64'(v.expHit));
    checkValue("exhausted", 64'(exhausted), 64'(!v.expHit));
    checkValue("nonce", 64'(nonce), 64'(v.expHit ? v.expNonce : expNonceReg));
    checkValue("hash_out", 64'(hash_out), 64'(v.isEmpty ? expHashReg : v.expHash));
    expBusy = 0;
`ifdef NONCE_SEARCH_CONT_EN
    expBusy = v.expHit && (v.expNonce != v.ne);
    begin
      int nValid;
      int lastV;
      bit sawEx;
      nValid = int'(valid);
      sawEx  = exhausted;
      lastV  = evEdge;
      checkValue("busy at first result", 64'(busy), 64'(expBusy));
      for (int i = 0; i < v.span + 20 && busy; i++) begin
        @(posedge clk); #1;
        if (valid) begin
          nValid++;
          checkValue("valid spacing ok", 64'((edgeCnt - startEdge - lastV) >= 17), 64'(1));
          lastV = edgeCnt - startEdge;
        end
        if (exhausted) sawEx = 1;
        if (valid && exhausted) checkValue("valid with exhausted", 64'(1), 64'(0));
      end
      checkValue("search ended", 64'(busy), 64'(0));
      checkValue("valid count", 64'(nValid), 64'(v.hitCount));
      checkValue("final exhausted", 64'(sawEx), 64'(v.finalMiss));
      if (v.hitCount > 0) expNonceReg = v.lastHitNonce;
      if (!v.isEmpty) expHashReg = refHash(v.hdr, v.ne);
      checkValue("final nonce", 64'(nonce), 64'(expNonceReg));
      checkValue("final hash_out", 64'(hash_out), 64'(expHashReg));
    end
`else
    checkValue("busy at result", 64'(busy), 64'(expBusy));
    if (v.expHit) expNonceReg = v.expNonce;
    if (!v.isEmpty) expHashReg = v.expHash;
`endif
    @(posedge clk); #1;
    checkValue("pulse width", 64'({valid, exhausted}), 64'(0));
  endtask

  initial begin
    vec_t hv;
    reset = 1'b1; start = 1'b0; header = '0; target = '0;
    nonce_start = '0; nonce_end = '0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset busy", 64'(busy), 64'(0));
    checkValue("reset valid", 64'(valid), 64'(0));
    checkValue("reset nonce", 64'(nonce), 64'(0));
    checkValue("reset exhausted", 64'(exhausted), 64'(0));
    checkValue("reset hash_out", 64'(hash_out), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = makeVec({$urandom, $urandom, $urandom}, 8'h00, 32'd5, 32'd7);
    vecs[1] = makeVec({$urandom, $urandom, $urandom}, 8'hFF, 32'd0, 32'd999);
    vecs[2] = makeVec({$urandom, $urandom, $urandom}, 8'h80, 32'd10, 32'd3);
    vecs[3] = makeVec({$urandom, $urandom, $urandom}, 8'h00, 32'hFFFFFFFE, 32'hFFFFFFFF);
    vecs[4] = makeVec({$urandom, $urandom, $urandom}, 8'hFF, 32'hFFFFFFFE, 32'hFFFFFFFF);
    vecs[5] = makeVec({$urandom, $urandom, $urandom}, 8'h10, 32'd100, 32'd130);
    for (int i = 6; i < 12; i++) begin
      logic [31:0] s;
      s = $urandom_range(0, 32'h7FFFFFFF);
      vecs[i] = makeVec({$urandom, $urandom, $urandom}, 8'($urandom_range(0, 255)),
                        s, s + $urandom_range(0, 15));
    end

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], 0);
      checkOutput(vecs[i]);
    end

    // start held high through most of a search must not disturb it
    hv = makeVec({$urandom, $urandom, $urandom}, 8'h00, 32'd20, 32'd22);
    applyStimulus(hv, 40);
    checkOutput(hv);

    // a search that leaves nonce/hash_out non-zero, then reset mid-HASH
    hv = makeVec({$urandom, $urandom, $urandom}, 8'hFF, 32'd100, 32'd200);
    applyStimulus(hv, 0);
    checkOutput(hv);
    hv = makeVec({$urandom, $urandom, $urandom}, 8'h00, 32'd1, 32'd4);
    applyStimulus(hv, 0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkValue("mid reset busy", 64'(busy), 64'(0));
    checkValue("mid reset valid", 64'(valid), 64'(0));
    checkValue("mid reset nonce", 64'(nonce), 64'(0));
    checkValue("mid reset exhausted", 64'(exhausted), 64'(0));
    checkValue("mid reset hash_out", 64'(hash_out), 64'(0));
    expNonceReg = '0;
    expHashReg  = '0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(vecs[5], 0);
    checkOutput(vecs[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
